msdf_stream_to_bin: RTL and testbench
=====================================

# msdf_stream_to_bin

Elastic sink that consumes a most-significant-digit-first (MSDF) signed-digit stream, such as the output of the MSDF multiplier, and rebuilds the conventional two's-complement value. It uses on-the-fly conversion, so no carry-propagate step is needed at the end of a frame. The block sits at the exit of an MSDF datapath and hands one parallel word per frame to downstream elastic logic. It has the same Join/OEHB-style valid/ready handshake as the digit producers.

## Interface
Parameters:
- TARGET_PRECISION, 32'd16: number of fraction digits per frame (N), with N ≥ 2.
- OUT_WIDTH, TARGET_PRECISION+1: width of the result. It is fixed to N+1 (sign bit plus N fraction bits, Q1.N).

Ports:
- clk  input  1  clock
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- dataInArray_0  input  3  {last, digit[1:0]}. Digit encoding: 2'b10 = +1, 2'b01 = −1, 2'b00 or 2'b11 = 0.
- pValidArray_0  input  1  input digit valid
- readyArray_0  output  1  block accepts a digit
- dataOutArray_0  output  OUT_WIDTH  converted value, two's complement. The value is the sum of d_i·2^(N−i) for i = 1..N.
- validArray_0  output  1  result valid
- nReadyArray_0  input  1  downstream accepts the result

## Operation
- Internal registers:
  - Q and QM, each OUT_WIDTH wide. The invariant QM = Q − 1 holds at all times.
  - Digit counter cnt, 0..N.
  - Pending-last flag.
  - State register with three states: ACC, PAD, HOLD.
- Frame start (reset or after a handoff): Q = 0, QM = all ones, cnt = 0, state = ACC.
- A digit is accepted on a clock edge where pValidArray_0 and readyArray_0 are both 1.
- Conversion update per digit d:
  - d = +1: Q ← {Q,1}, QM ← {Q,0}
  - d = 0: Q ← {Q,0}, QM ← {QM,1}
  - d = −1: Q ← {QM,1}, QM ← {QM,0}
  - {X,b} means shift X left by one and insert b; the result is truncated to OUT_WIDTH bits.
- cnt increments by 1 on every accepted digit and every pad digit.
- State ACC:
  - readyArray_0 = 1.
  - Accepting a digit with cnt+1 = N: go to HOLD. The last bit is ignored in this case.
  - Accepting a digit with last = 1 and cnt+1 < N: go to PAD.
- State PAD:
  - readyArray_0 = 0.
  - Each cycle applies a zero digit, which left-aligns an early-terminated frame.
  - When cnt reaches N, go to HOLD.
- State HOLD:
  - readyArray_0 = 0, validArray_0 = 1, dataOutArray_0 = Q (registered, stable).
  - On validArray_0 & nReadyArray_0: reinitialise Q, QM and cnt, then go to ACC.
- Digits are never dropped or duplicated.
- Back-to-back frames are supported: the first digit of the next frame is accepted in the cycle after the handoff.
- Reset mid-frame: all partial state is discarded and the next accepted digit starts a new frame.

## Timing
- Reset values:
  - readyArray_0 = 0 while rst = 1, and 1 from the first cycle after rst deasserts.
  - validArray_0 = 0.
  - dataOutArray_0 = 0.
- readyArray_0 and validArray_0 are decoded from registered state only. They have no combinational path from pValidArray_0 or nReadyArray_0.
- Latency: validArray_0 rises on the clock edge that accepts the N-th digit. For an early last at digit k, it rises N−k cycles after the accepting edge.
- Minimum frame period: N+1 cycles (N digit cycles plus 1 handoff cycle).
- Backpressure: HOLD persists indefinitely while nReadyArray_0 = 0. Output data does not change while valid = 1 and the handshake has not completed.
- Handshake on an arbitrary cycle: a valid/ready pair can complete on any cycle. The input side may deassert pValidArray_0 between digits without any effect on Q or QM.
- Range: results span −(2^N−1) .. +(2^N−1). They never overflow OUT_WIDTH.

## Test plan
All scenarios use N = 16.

1. Sixteen +1 digits, last on the 16th, nReadyArray_0 = 1 → dataOutArray_0 = 17'h0FFFF. Valid rises on the 16th accept edge and lasts 1 cycle.
2. Sixteen −1 digits → 17'h10001.
3. Digit −1 followed by fifteen +1 digits → 17'h1FFFF (−1). This exercises the Q ← QM path.
4. Single +1 digit with last = 1 → readyArray_0 low for 15 pad cycles, then 17'h08000. The sequence +1, −1 (last) → 17'h04000. 2'b11 digits in the stream act as zero.
5. nReadyArray_0 held 0 for 5 cycles in HOLD → data stable and readyArray_0 = 0 throughout. After the handshake, the next frame's digits are accepted in the very next cycle and convert correctly.
6. rst pulsed for 1 cycle after 7 digits → valid = 0 and data = 0. The next 16 digits of all +1 yield 17'h0FFFF. pValidArray_0 is also toggled randomly mid-frame, with no change in the result.

Source files
------------

// File: rtl/msdf_stream_to_bin.sv
// msdf_stream_to_bin: converts an MSDF signed-digit stream into a two's-complement
// Q1.N word using on-the-fly conversion (Q / QM register pair), with an elastic
// valid/ready handshake on both sides. Early-terminated frames are left-aligned
// by padding zero digits before the result is presented.
module msdf_stream_to_bin #(
  parameter int unsigned TARGET_PRECISION = 32'd16,
  parameter int unsigned OUT_WIDTH        = TARGET_PRECISION + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           dataInArray_0,
  input  logic                 pValidArray_0,
  output logic                 readyArray_0,
  output logic [OUT_WIDTH-1:0] dataOutArray_0,
  output logic                 validArray_0,
  input  logic                 nReadyArray_0
);

  localparam int unsigned CW = $clog2(TARGET_PRECISION + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(TARGET_PRECISION - 1);

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    PAD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [OUT_WIDTH-1:0] q, qm, q_nxt, qm_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;

  // One on-the-fly conversion step; returns {Q', QM'} so QM' = Q' - 1 is kept.
  // Digit 2'b10 = +1, 2'b01 = -1, anything else is zero.
  function automatic logic [2*OUT_WIDTH-1:0] otf_step(
    input logic [OUT_WIDTH-1:0] q_i,
    input logic [OUT_WIDTH-1:0] qm_i,
    input logic [1:0]           d
  );
    logic [2*OUT_WIDTH-1:0] r;
    case (d)
      2'b10:   r = {q_i[OUT_WIDTH-2:0], 1'b1, q_i[OUT_WIDTH-2:0], 1'b0};
      2'b01:   r = {qm_i[OUT_WIDTH-2:0], 1'b1, qm_i[OUT_WIDTH-2:0], 1'b0};
      default: r = {q_i[OUT_WIDTH-2:0], 1'b0, qm_i[OUT_WIDTH-2:0], 1'b1};
    endcase
    return r;
  endfunction

  // Next-state logic: digit accumulation, zero padding and result handoff.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    qm_nxt    = qm;
    cnt_nxt   = cnt;
    case (state)
      ACC: begin
        if (pValidArray_0) begin
          {q_nxt, qm_nxt} = otf_step(q, qm, dataInArray_0[1:0]);
          cnt_nxt = cnt + CW'(1);
          // A full frame ends on the N-th digit regardless of the last flag.
          if (cnt == LAST_IDX)       state_nxt = HOLD;
          else if (dataInArray_0[2]) state_nxt = PAD;
        end
      end
      PAD: begin
        {q_nxt, qm_nxt} = otf_step(q, qm, 2'b00);
        cnt_nxt = cnt + CW'(1);
        if (cnt == LAST_IDX) state_nxt = HOLD;
      end
      HOLD: begin
        if (nReadyArray_0) begin
          q_nxt     = '0;
          qm_nxt    = '1;
          cnt_nxt   = '0;
          state_nxt = ACC;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  // State and conversion registers; reset restarts the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      q     <= '0;
      qm    <= '1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      qm    <= qm_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Handshake outputs come from registered state only (rst only masks them).
  assign readyArray_0   = (state == ACC) && !rst;
  assign validArray_0   = (state == HOLD) && !rst;
  assign dataOutArray_0 = q;

endmodule

// File: tb/tb_msdf_stream_to_bin.sv
// Testbench for msdf_stream_to_bin: frames are driven digit by digit, the
// expected word and valid-rise cycle are queued, and a monitor checks every
// presented result, its stability under backpressure and handshake timing.
module tb_msdf_stream_to_bin;
  localparam int N     = 16;
  localparam int OUT_W = N + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       dataInArray_0;
  logic             pValidArray_0;
  logic             readyArray_0;
  logic [OUT_W-1:0] dataOutArray_0;
  logic             validArray_0;
  logic             nReadyArray_0;

  msdf_stream_to_bin #(.TARGET_PRECISION(N)) dut (
    .clk(clk), .rst(rst),
    .dataInArray_0(dataInArray_0), .pValidArray_0(pValidArray_0),
    .readyArray_0(readyArray_0),
    .dataOutArray_0(dataOutArray_0), .validArray_0(validArray_0),
    .nReadyArray_0(nReadyArray_0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] val;
    int               rise;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  int         edges = 0;
  int         stall_n = 0;
  bit         rand_bp = 0;
  bit         gaps = 0;
  logic [1:0] fd[$];
  bit         use_last;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic int dval(input logic [1:0] d);
    if (d == 2'b10) return 1;
    if (d == 2'b01) return -1;
    return 0;
  endfunction

  // Reference: value = sum d_i * 2^(N-i) over the supplied digits.
  function automatic logic [OUT_W-1:0] ref_val();
    int v = 0;
    foreach (fd[i]) v += dval(fd[i]) * (1 << (N - 1 - i));
    return OUT_W'(v);
  endfunction

  task automatic put_digit(input logic [1:0] d, input bit last, output int acc_edge);
    int w = 0;
    if (gaps)
      while ($urandom_range(0, 3) == 0) begin
        pValidArray_0 = 1'b0;
        dataInArray_0 = 3'($urandom);
        @(posedge clk); #1;
      end
    pValidArray_0 = 1'b1;
    dataInArray_0 = {last, d};
    @(negedge clk);
    while (!readyArray_0) begin
      w++;
      if (w > 200) begin
        $display("FAIL accept_timeout actual=%0d required=<200", w);
        $fatal(1, "digit never accepted");
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    acc_edge      = edges;
    pValidArray_0 = 1'b0;
    dataInArray_0 = 3'($urandom);
  endtask

  task automatic send_frame();
    int   e = 0;
    exp_t x;
    foreach (fd[i]) put_digit(fd[i], use_last && (i == fd.size() - 1), e);
    x.val  = ref_val();
    x.rise = e + (N - fd.size());
    sb.push_back(x);
  endtask

  task automatic fill(input logic [1:0] d, input int n);
    fd.delete();
    for (int i = 0; i < n; i++) fd.push_back(d);
  endtask

  task automatic rand_frame();
    int k;
    logic [1:0] pick;
    fd.delete();
    k = ($urandom_range(0, 1) == 1) ? N : $urandom_range(1, N - 1);
    for (int i = 0; i < k; i++) begin
      pick = 2'($urandom);
      fd.push_back(pick);
    end
    use_last = (k < N) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  // Downstream ready: forced stalls take priority, else random or always-ready.
  initial begin
    nReadyArray_0 = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_n > 0 && validArray_0) begin
        nReadyArray_0 = 1'b0;
        stall_n--;
      end else if (rand_bp) nReadyArray_0 = ($urandom_range(0, 2) != 0);
      else nReadyArray_0 = 1'b1;
    end
  end

  // Monitor: pop/compare on each new result, check stability and handoff.
  initial begin
    bit               seen = 0;
    bit               held = 0;
    bit               hs_prev = 0;
    logic [OUT_W-1:0] held_val = '0;
    exp_t             x;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0; held = 0; hs_prev = 0;
      end else begin
        if (hs_prev) chk("ready_after_handoff", 32'(readyArray_0), 32'd1);
        hs_prev = 0;
        if (validArray_0) begin
          chk("ready_low_in_hold", 32'(readyArray_0), 32'd0);
          if (!seen) begin
            seen = 1;
            if (sb.size() == 0) begin
              chk("unexpected_valid", 32'(validArray_0), 32'd0);
            end else begin
              x = sb.pop_front();
              chk("result", 32'(dataOutArray_0), 32'(x.val));
              chk("valid_rise_edge", 32'(edges), 32'(x.rise));
            end
          end else if (held) begin
            chk("data_stable", 32'(dataOutArray_0), 32'(held_val));
          end
          if (nReadyArray_0) begin
            held = 0; seen = 0; hs_prev = 1;
          end else begin
            held = 1; held_val = dataOutArray_0;
          end
        end
      end
    end
  end

  initial begin
    int e;
    int w;
    rst = 1'b1;
    pValidArray_0 = 1'b0;
    dataInArray_0 = 3'b000;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_in_reset", 32'(readyArray_0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(validArray_0), 32'd0);
    chk("reset_data", 32'(dataOutArray_0), 32'd0);
    chk("reset_ready", 32'(readyArray_0), 32'd1);
    @(posedge clk); #1;

    // Directed frames with an always-ready sink.
    use_last = 1; fill(2'b10, N); send_frame();            // 0FFFF
    fill(2'b01, N); send_frame();                          // 10001
    fill(2'b10, N); fd[0] = 2'b01; send_frame();           // 1FFFF
    fill(2'b10, 1); send_frame();                          // 08000
    fd.delete(); fd.push_back(2'b10); fd.push_back(2'b11);
    fd.push_back(2'b01); send_frame();                     // 06000 with a 2'b11 zero
    fd.delete(); fd.push_back(2'b10); fd.push_back(2'b01);
    send_frame();                                          // 04000

    // Backpressure for 5 cycles, then an immediate back-to-back frame.
    stall_n = 5;
    fill(2'b01, N); fd[3] = 2'b10; send_frame();
    fill(2'b10, N); fd[N-1] = 2'b01; send_frame();

    // Reset after 7 digits discards the partial frame.
    gaps = 1;
    for (int i = 0; i < 7; i++) put_digit(2'b01, 1'b0, e);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_mid_reset", 32'(readyArray_0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_valid", 32'(validArray_0), 32'd0);
    chk("post_reset_data", 32'(dataOutArray_0), 32'd0);
    @(posedge clk); #1;
    use_last = 1; fill(2'b10, N); send_frame();

    // Randomized frames with input gaps and random backpressure.
    rand_bp = 1;
    for (int f = 0; f < 40; f++) begin
      rand_frame();
      send_frame();
    end

    w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
